// File: rtl/mem_access_pipe.sv
// mem_access_pipe: pipelined AHB-Lite memory stage between execute and write-back.
// Optional MEM_ACCESS_HRESP_EN adds HRESP error handling and bus_err_o.
module mem_access_pipe #(
    parameter int XLEN = 64,
    parameter int AW   = 64
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            EN,
    input  logic            LOAD,
    input  logic [1:0]      SIZE,
    input  logic            UNSIGNED,
    input  logic [AW-1:0]   address,
    input  logic [XLEN-1:0] value,
    input  logic [XLEN-1:0] alu_res,
    input  logic [4:0]      rd_i,
    input  logic            write_back,
    input  logic            branch_flag_i,
    input  logic [XLEN-1:0] branch_offset_i,
    input  logic [XLEN-1:0] HRDATA,
    input  logic            HREADY,
`ifdef MEM_ACCESS_HRESP_EN
    input  logic            HRESP,
    output logic            bus_err_o,
`endif
    output logic [AW-1:0]   HADDR,
    output logic [XLEN-1:0] HWDATA,
    output logic            HWRITE,
    output logic [1:0]      HTRANS,
    output logic [2:0]      HSIZE,
    output logic [XLEN-1:0] res,
    output logic [4:0]      rd_o,
    output logic            mem_write_back_en,
    output logic            take_branch,
    output logic [XLEN-1:0] branch_offset_o,
    output logic            stall_o,
    output logic            misalign_o
);

    localparam int OW = (XLEN == 64) ? 3 : 2;
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0]   haddr_q, haddr_d;
    logic [XLEN-1:0] hwdata_q, hwdata_d;
    logic            hwrite_q, hwrite_d;
    logic [1:0]      htrans_q, htrans_d;
    logic [2:0]      hsize_q, hsize_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [4:0]      rd_q, rd_d;
    logic            wb_q, wb_d;
    logic            take_branch_q, take_branch_d;
    logic [XLEN-1:0] br_off_q, br_off_d;
    logic            stall_q, stall_d;
    logic            misalign_q, misalign_d;
    logic [4:0]      l_rd_q, l_rd_d;
    logic            l_wb_q, l_wb_d;
    logic            l_load_q, l_load_d;
    logic [1:0]      l_size_q, l_size_d;
    logic            l_uns_q, l_uns_d;
    logic [XLEN-1:0] l_val_q, l_val_d;
    logic [OW-1:0]   l_off_q, l_off_d;
`ifdef MEM_ACCESS_HRESP_EN
    logic            bus_err_q, bus_err_d;
`endif

    logic [2:0] align_mask;
    logic       bad_access;

    // Replicate the low (8<<sz) bits of the store value across every lane
    function automatic logic [XLEN-1:0] lane_rep(
        input logic [XLEN-1:0] v,
        input logic [1:0]      sz
    );
        logic [XLEN-1:0] r;
        int nb;
        r  = '0;
        nb = 1 << sz;
        for (int i = 0; i < XLEN / 8; i++) begin
            r[i*8 +: 8] = v[(i & (nb - 1))*8 +: 8];
        end
        return r;
    endfunction

    // Align the addressed lane to bit 0 and extend to XLEN
    function automatic logic [XLEN-1:0] load_ext(
        input logic [XLEN-1:0] d,
        input logic [OW-1:0]   off,
        input logic [1:0]      sz,
        input logic            uns
    );
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] r;
        int bits;
        sh   = d >> {off, 3'b000};
        r    = sh;
        bits = 8 << sz;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= bits) begin
                r[i] = uns ? 1'b0 : sh[bits-1];
            end
        end
        return r;
    endfunction

    // Alignment / legality check of the incoming access
    always_comb begin
        align_mask = 3'b000;
        case (SIZE)
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        bad_access = (|(address[2:0] & align_mask))
                   || ((SIZE == 2'd3) && (XLEN == 32));
    end

    // Next-state and output computation for the IDLE/ADDR/DATA FSM
    always_comb begin
        state_d       = state_q;
        haddr_d       = haddr_q;
        hwdata_d      = hwdata_q;
        hwrite_d      = hwrite_q;
        htrans_d      = htrans_q;
        hsize_d       = hsize_q;
        res_d         = res_q;
        rd_d          = rd_q;
        wb_d          = wb_q;
        take_branch_d = 1'b0;
        br_off_d      = branch_offset_i;
        stall_d       = stall_q;
        misalign_d    = 1'b0;
        l_rd_d        = l_rd_q;
        l_wb_d        = l_wb_q;
        l_load_d      = l_load_q;
        l_size_d      = l_size_q;
        l_uns_d       = l_uns_q;
        l_val_d       = l_val_q;
        l_off_d       = l_off_q;
`ifdef MEM_ACCESS_HRESP_EN
        bus_err_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                take_branch_d = branch_flag_i
                              && (alu_res == XLEN'(1));
                if (take_branch_q) begin
                    rd_d = 5'd0;
                    wb_d = 1'b0;
                end else if (!EN) begin
                    res_d = alu_res;
                    rd_d  = rd_i;
                    wb_d  = write_back;
                end else if (bad_access) begin
                    misalign_d = 1'b1;
                    wb_d       = 1'b0;
                end else begin
                    htrans_d = HT_NONSEQ;
                    haddr_d  = address;
                    hwrite_d = ~LOAD;
                    hsize_d  = {1'b0, SIZE};
                    l_rd_d   = rd_i;
                    l_wb_d   = write_back;
                    l_load_d = LOAD;
                    l_size_d = SIZE;
                    l_uns_d  = UNSIGNED;
                    l_val_d  = value;
                    l_off_d  = address[OW-1:0];
                    stall_d  = 1'b1;
                    wb_d     = 1'b0;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    htrans_d = HT_IDLE;
                    if (!l_load_q) begin
                        hwdata_d = lane_rep(l_val_q, l_size_q);
                    end
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    if (l_load_q) begin
                        res_d = load_ext(HRDATA, l_off_q,
                                         l_size_q, l_uns_q);
                    end
                    rd_d    = l_rd_q;
                    wb_d    = l_wb_q;
`ifdef MEM_ACCESS_HRESP_EN
                    if (HRESP) begin
                        res_d     = res_q;
                        wb_d      = 1'b0;
                        bus_err_d = 1'b1;
                    end
`endif
                    stall_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q       <= S_IDLE;
            haddr_q       <= '0;
            hwdata_q      <= '0;
            hwrite_q      <= 1'b0;
            htrans_q      <= HT_IDLE;
            hsize_q       <= '0;
            res_q         <= '0;
            rd_q          <= '0;
            wb_q          <= 1'b0;
            take_branch_q <= 1'b0;
            br_off_q      <= '0;
            stall_q       <= 1'b0;
            misalign_q    <= 1'b0;
            l_rd_q        <= '0;
            l_wb_q        <= 1'b0;
            l_load_q      <= 1'b0;
            l_size_q      <= '0;
            l_uns_q       <= 1'b0;
            l_val_q       <= '0;
            l_off_q       <= '0;
`ifdef MEM_ACCESS_HRESP_EN
            bus_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            haddr_q       <= haddr_d;
            hwdata_q      <= hwdata_d;
            hwrite_q      <= hwrite_d;
            htrans_q      <= htrans_d;
            hsize_q       <= hsize_d;
            res_q         <= res_d;
            rd_q          <= rd_d;
            wb_q          <= wb_d;
            take_branch_q <= take_branch_d;
            br_off_q      <= br_off_d;
            stall_q       <= stall_d;
            misalign_q    <= misalign_d;
            l_rd_q        <= l_rd_d;
            l_wb_q        <= l_wb_d;
            l_load_q      <= l_load_d;
            l_size_q      <= l_size_d;
            l_uns_q       <= l_uns_d;
            l_val_q       <= l_val_d;
            l_off_q       <= l_off_d;
`ifdef MEM_ACCESS_HRESP_EN
            bus_err_q     <= bus_err_d;
`endif
        end
    end

    assign HADDR             = haddr_q;
    assign HWDATA            = hwdata_q;
    assign HWRITE            = hwrite_q;
    assign HTRANS            = htrans_q;
    assign HSIZE             = hsize_q;
    assign res               = res_q;
    assign rd_o              = rd_q;
    assign mem_write_back_en = wb_q;
    assign take_branch       = take_branch_q;
    assign branch_offset_o   = br_off_q;
    assign stall_o           = stall_q;
    assign misalign_o        = misalign_q;
`ifdef MEM_ACCESS_HRESP_EN
    assign bus_err_o         = bus_err_q;
`endif

endmodule
